// File: rtl/ast_pkg.sv
// AST controller shared definitions.
// Holds the FSM state encoding and the fire command constant.
package ast_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARM      = 3'd1,
    S_FIRE     = 3'd2,
    S_WAIT_ON  = 3'd3,
    S_WAIT_OFF = 3'd4,
    S_NEXT     = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  localparam logic [7:0] AST_CMD_FIRE = 8'h1;
  localparam logic [7:0] AST_CMD_IDLE = 8'h0;

endpackage

// File: rtl/ast_us_tick.sv
// Free-running microsecond tick generator.
// Ports: clk_sys, rst_n (sync, active-low), cfg_div (cycles/us - 1),
//        pluse_us (registered one-cycle tick).
module ast_us_tick (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic [7:0] cfg_div,
  output logic       pluse_us
);

  logic [7:0] cnt;

  // Wrap on >= so a live shrink of cfg_div never runs a full 256 lap.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      cnt      <= 8'd0;
      pluse_us <= 1'b0;
    end else begin
      pluse_us <= (cnt == cfg_div);
      if (cnt >= cfg_div) cnt <= 8'd0;
      else                cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/ast_ctrl.sv
// AST fire controller: periodic fire commands with handshake monitoring.
// Ports: clk_sys, rst_n (sync, active-low), cfg_div/period/burst/pol,
//        cmd_start, cmd_stop, ast_mon -> pluse_us, cmd_ast, busy, done,
//        fire_cnt, err_to (all outputs registered).
module ast_ctrl
  import ast_pkg::*;
#(
  parameter logic [15:0] TO_US = 16'd1000
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [7:0]  cfg_div,
  input  logic [15:0] cfg_period,
  input  logic [7:0]  cfg_burst,
  input  logic [7:0]  cfg_pol,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  input  logic        ast_mon,
  output logic        pluse_us,
  output logic [7:0]  cmd_ast,
  output logic        busy,
  output logic        done,
  output logic [7:0]  fire_cnt,
  output logic        err_to
);

  state_t      state;
  logic [15:0] us_cnt;
  logic        stop_pend;
  logic        ast_act;
  logic [7:0]  cnt_nxt;
  logic        last;

  ast_us_tick u_tick (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .cfg_div  (cfg_div),
    .pluse_us (pluse_us)
  );

  assign ast_act = (cfg_pol == 8'h0) ? ast_mon : ~ast_mon;
  assign cnt_nxt = fire_cnt + 8'd1;
  assign last    = stop_pend ||
                   ((cfg_burst != 8'h0) && (cnt_nxt == cfg_burst));

  // busy/done/cmd_ast are set on the transition into their state so
  // that the registered outputs line up with the state they describe.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      us_cnt    <= 16'd0;
      stop_pend <= 1'b0;
      cmd_ast   <= AST_CMD_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      fire_cnt  <= 8'd0;
      err_to    <= 1'b0;
    end else begin
      cmd_ast <= AST_CMD_IDLE;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (cmd_start && !cmd_stop) begin
            state     <= S_ARM;
            busy      <= 1'b1;
            fire_cnt  <= 8'd0;
            err_to    <= 1'b0;
            us_cnt    <= 16'd0;
            stop_pend <= 1'b0;
          end
        end
        S_ARM: begin
          if (cmd_stop) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else if (us_cnt >= cfg_period) begin
            state   <= S_FIRE;
            cmd_ast <= AST_CMD_FIRE;
          end else if (pluse_us) begin
            us_cnt <= us_cnt + 16'd1;
          end
        end
        S_FIRE: begin
          if (cmd_stop) stop_pend <= 1'b1;
          state  <= S_WAIT_ON;
          us_cnt <= 16'd0;
        end
        S_WAIT_ON: begin
          if (cmd_stop) stop_pend <= 1'b1;
          if (ast_act) begin
            state <= S_WAIT_OFF;
          end else if (us_cnt >= TO_US) begin
            err_to <= 1'b1;
            state  <= S_DONE;
            done   <= 1'b1;
          end else if (pluse_us) begin
            us_cnt <= us_cnt + 16'd1;
          end
        end
        S_WAIT_OFF: begin
          if (cmd_stop) stop_pend <= 1'b1;
          if (!ast_act) state <= S_NEXT;
        end
        S_NEXT: begin
          fire_cnt <= cnt_nxt;
          if (last) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state  <= S_ARM;
            us_cnt <= 16'd0;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          stop_pend <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
